// File: rtl/data_mem_responder_if.sv
// Core/loader <-> data-memory bus bundle.
//   master : core + preloader side (drives address/data/strobes, observes read data and status)
//   slave  : memory responder side
//   RAM_IN_ADDRESS/RAM_IN_DATA/RAM_IN_WRITE -> RAM_OUT : core word access, combinational read
//   ld_valid/ld_ready/ld_addr/ld_data                 : preload write handshake
//   ready, err_oob, wr_count, mmio_out                : status and output register
interface data_mem_responder_if;
  logic [31:0] RAM_IN_ADDRESS;
  logic [31:0] RAM_IN_DATA;
  logic        RAM_IN_WRITE;
  logic [31:0] RAM_OUT;
  logic        ready;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        err_oob;
  logic [15:0] wr_count;
  logic [31:0] mmio_out;

  modport master (
    output RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE, ld_valid, ld_addr, ld_data,
    input  RAM_OUT, ready, ld_ready, err_oob, wr_count, mmio_out
  );

  modport slave (
    input  RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE, ld_valid, ld_addr, ld_data,
    output RAM_OUT, ready, ld_ready, err_oob, wr_count, mmio_out
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering the core's MEM stage.
// Zero-latency read, clocked write, zero-clear sweep after reset, and a
// valid/ready preload port that yields to core stores.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : data_mem_responder_if.slave (core access, preload, status)
// Optional feature: define DMEM_MMIO_EN to map an output register at MMIO_BASE.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state;
  logic [AW-1:0] clr_idx;
  logic        ready_q;
  logic        err_oob_q;
  logic [15:0] wr_count_q;
  logic [31:0] mmio_q;

  logic [31:0] mem [DEPTH];

  logic          run;
  logic [AW-1:0] core_idx;
  logic [AW-1:0] ld_idx;
  logic          core_in_range;
  logic          ld_in_range;
  logic          mmio_hit;
  logic          core_commit;
  logic          ld_fire;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  // Address decode shared by read, write and status paths
  assign run           = (state == RUN);
  assign core_idx      = bus.RAM_IN_ADDRESS[AW-1:0];
  assign ld_idx        = bus.ld_addr[AW-1:0];
  assign core_in_range = (bus.RAM_IN_ADDRESS < 32'(DEPTH));
  assign ld_in_range   = (bus.ld_addr < 32'(DEPTH));
  assign mmio_hit      = MMIO_EN && (bus.RAM_IN_ADDRESS == MMIO_BASE);
  // MMIO_BASE is never in range, so only the MMIO hit needs adding here
  assign core_commit   = run && bus.RAM_IN_WRITE && (core_in_range || mmio_hit);
  assign ld_fire       = bus.ld_valid && bus.ld_ready;

  // Core stores have priority; the loader only sees ready when the core is idle
  assign bus.ld_ready = run && !bus.RAM_IN_WRITE;

  // Combinational read; zero outside RUN and for unmapped addresses
  always_comb begin
    bus.RAM_OUT = '0;
    if (run) begin
      if (mmio_hit)           bus.RAM_OUT = mmio_q;
      else if (core_in_range) bus.RAM_OUT = mem[core_idx];
    end
  end

  // Single memory write port: sweep, core store or preload (mutually exclusive)
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (!run) begin
        mem_we   = 1'b1;
        mem_widx = clr_idx;
      end else if (bus.RAM_IN_WRITE) begin
        mem_we    = core_in_range;
        mem_widx  = core_idx;
        mem_wdata = bus.RAM_IN_DATA;
      end else if (ld_fire) begin
        mem_we    = ld_in_range;
        mem_widx  = ld_idx;
        mem_wdata = bus.ld_data;
      end
    end
  end

  // Storage array, no reset; the sweep provides the cleared state
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      ready_q    <= 1'b0;
      err_oob_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          // Every cycle is a read of the presented address
          if (!core_in_range && !mmio_hit) err_oob_q <= 1'b1;
          if (core_commit && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  // Memory-mapped output register
  always_ff @(posedge clk) begin
    if (!rst_n)                                  mmio_q <= '0;
    else if (run && bus.RAM_IN_WRITE && mmio_hit) mmio_q <= bus.RAM_IN_DATA;
  end
`else
  assign mmio_q = '0;
`endif

  assign bus.ready    = ready_q;
  assign bus.err_oob  = err_oob_q;
  assign bus.wr_count = wr_count_q;
  assign bus.mmio_out = mmio_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed test of data_mem_responder (DEPTH=256).
module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH     (256),
    .MMIO_BASE (32'hFFFF_FF00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.RAM_IN_ADDRESS = '0;
    bus.RAM_IN_DATA    = '0;
    bus.RAM_IN_WRITE   = 1'b0;
    bus.ld_valid       = 1'b0;
    bus.ld_addr        = '0;
    bus.ld_data        = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready",    32'(bus.ready), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_err",      32'(bus.err_oob), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_ram_out",  bus.RAM_OUT, 32'd0);
    check("rst_mmio",     bus.mmio_out, 32'd0);

    // Sweep takes exactly 256 cycles
    rst_n = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      check("sweep1_ready_low", 32'(bus.ready), 32'd0);
    end
    tick();
    check("sweep1_ready_high", 32'(bus.ready), 32'd1);

    // Whole array reads zero
    for (int i = 0; i < 256; i++) begin
      bus.RAM_IN_ADDRESS = 32'(i);
      #1;
      check("clear_read", bus.RAM_OUT, 32'd0);
      tick();
    end
    check("post_clear_err", 32'(bus.err_oob), 32'd0);
    check("post_clear_wr",  32'(bus.wr_count), 32'd0);

    // Store then read; same-cycle read sees old value
    bus.RAM_IN_ADDRESS = 32'd5;
    bus.RAM_IN_DATA    = 32'hDEAD_BEEF;
    bus.RAM_IN_WRITE   = 1'b1;
    #1;
    check("store_same_cycle_old", bus.RAM_OUT, 32'd0);
    check("store_ld_ready_low",   32'(bus.ld_ready), 32'd0);
    tick();
    bus.RAM_IN_WRITE = 1'b0;
    #1;
    check("store_readback", bus.RAM_OUT, 32'hDEAD_BEEF);
    check("store_wr_count", 32'(bus.wr_count), 32'd1);

    // Preload stalled by a core store to another word
    bus.RAM_IN_ADDRESS = 32'd9;
    bus.RAM_IN_DATA    = 32'h0000_0099;
    bus.RAM_IN_WRITE   = 1'b1;
    bus.ld_valid       = 1'b1;
    bus.ld_addr        = 32'd7;
    bus.ld_data        = 32'h1234_5678;
    #1;
    check("ld_stall_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    bus.RAM_IN_WRITE   = 1'b0;
    bus.RAM_IN_ADDRESS = 32'd7;
    #1;
    check("ld_not_written",  bus.RAM_OUT, 32'd0);
    check("ld_ready_idle",   32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    check("ld_readback",     bus.RAM_OUT, 32'h1234_5678);
    check("ld_wr_count",     32'(bus.wr_count), 32'd2);
    bus.RAM_IN_ADDRESS = 32'd9;
    #1;
    check("core_store_9",    bus.RAM_OUT, 32'h0000_0099);

    // Marker word near the top of the array
    bus.RAM_IN_ADDRESS = 32'd250;
    bus.RAM_IN_DATA    = 32'h5555_AAAA;
    bus.RAM_IN_WRITE   = 1'b1;
    tick();
    bus.RAM_IN_WRITE = 1'b0;
    #1;
    check("marker_readback", bus.RAM_OUT, 32'h5555_AAAA);
    check("marker_wr_count", 32'(bus.wr_count), 32'd3);
    check("pre_oob_err",     32'(bus.err_oob), 32'd0);

    // Out-of-range store: dropped, uncounted, sticky error
    bus.RAM_IN_ADDRESS = 32'd300;
    bus.RAM_IN_DATA    = 32'hCAFE_F00D;
    bus.RAM_IN_WRITE   = 1'b1;
    #1;
    check("oob_read_zero", bus.RAM_OUT, 32'd0);
    tick();
    bus.RAM_IN_WRITE   = 1'b0;
    bus.RAM_IN_ADDRESS = 32'd44;
    #1;
    check("oob_err_set",      32'(bus.err_oob), 32'd1);
    check("oob_wr_count",     32'(bus.wr_count), 32'd3);
    check("oob_alias_intact", bus.RAM_OUT, 32'd0);
    tick();
    check("oob_err_sticky",   32'(bus.err_oob), 32'd1);

    // wr_count saturation
    for (int i = 0; i < 65540; i++) begin
      bus.RAM_IN_ADDRESS = 32'd0;
      bus.RAM_IN_DATA    = 32'(i);
      bus.RAM_IN_WRITE   = 1'b1;
      tick();
    end
    bus.RAM_IN_WRITE = 1'b0;
    #1;
    check("sat_wr_count", 32'(bus.wr_count), 32'h0000_FFFF);
    check("sat_last_data", bus.RAM_OUT, 32'd65539);

    // Restart sweep, then reset again at clr_idx=100
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    bus.RAM_IN_ADDRESS = 32'd250;
    bus.RAM_IN_DATA    = 32'h0BAD_0BAD;
    bus.RAM_IN_WRITE   = 1'b1;
    bus.ld_valid       = 1'b1;
    bus.ld_addr        = 32'd251;
    bus.ld_data        = 32'h7777_7777;
    #1;
    check("midsweep_ready",    32'(bus.ready), 32'd0);
    check("midsweep_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("midsweep_ram_out",  bus.RAM_OUT, 32'd0);
    rst_n = 1'b0;
    tick();
    bus.RAM_IN_WRITE = 1'b0;
    bus.ld_valid     = 1'b0;
    check("rst2_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst2_err",      32'(bus.err_oob), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      check("sweep2_ready_low", 32'(bus.ready), 32'd0);
    end
    tick();
    check("sweep2_ready_high", 32'(bus.ready), 32'd1);
    bus.RAM_IN_ADDRESS = 32'd250;
    #1;
    check("sweep2_cleared_250", bus.RAM_OUT, 32'd0);
    bus.RAM_IN_ADDRESS = 32'd0;
    #1;
    check("sweep2_cleared_0", bus.RAM_OUT, 32'd0);
    check("sweep2_wr_count",  32'(bus.wr_count), 32'd0);

    // Out-of-range preload: accepted, dropped, no error
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'd300;
    bus.ld_data  = 32'h1111_2222;
    #1;
    check("oob_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    bus.RAM_IN_ADDRESS = 32'd44;
    #1;
    check("oob_ld_no_err",   32'(bus.err_oob), 32'd0);
    check("oob_ld_no_alias", bus.RAM_OUT, 32'd0);

    // MMIO store
    bus.RAM_IN_ADDRESS = 32'hFFFF_FF00;
    bus.RAM_IN_DATA    = 32'h0000_00A5;
    bus.RAM_IN_WRITE   = 1'b1;
    tick();
    bus.RAM_IN_WRITE = 1'b0;
    #1;
`ifdef DMEM_MMIO_EN
    check("mmio_out",      bus.mmio_out, 32'h0000_00A5);
    check("mmio_read",     bus.RAM_OUT, 32'h0000_00A5);
    check("mmio_err",      32'(bus.err_oob), 32'd0);
    check("mmio_wr_count", 32'(bus.wr_count), 32'd1);
`else
    check("mmio_out",      bus.mmio_out, 32'd0);
    check("mmio_read",     bus.RAM_OUT, 32'd0);
    check("mmio_err",      32'(bus.err_oob), 32'd1);
    check("mmio_wr_count", 32'(bus.wr_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
